// File: rtl/ip_header_encoder.sv
`default_nettype none
// ============================================================================
// Module   : ip_header_encoder
// Purpose  : Latches a full set of IPv4 header fields on start, computes
//            the header checksum one 16-bit word per cycle (optional), and
//            emits the header as three 64-bit beats on a valid/ready stream.
//            The bit packing matches the receive-side decoder's beats 2-4.
// Revision : 1.0 - initial release
// ============================================================================
module ip_header_encoder #(
    parameter bit COMPUTE_CHECKSUM = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  version,
    input  logic [3:0]  header_length,
    input  logic [7:0]  type_of_service,
    input  logic [15:0] total_length,
    input  logic [15:0] identification,
    input  logic [2:0]  flags,
    input  logic [12:0] fragment_offset,
    input  logic [7:0]  time_to_live,
    input  logic [7:0]  protocol,
    input  logic [15:0] checksum_in,
    input  logic [31:0] src_ip_address,
    input  logic [31:0] dest_ip_address,
    output logic        busy,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [1:0]  out_beat,
    output logic [15:0] checksum_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_SEND0 = 3'd2,
        S_SEND1 = 3'd3,
        S_SEND2 = 3'd4
    } state_t;

    localparam logic [3:0] C_LAST_WORD = 4'd9;

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [15:0] r_acc;

    // Field registers: captured only at the accepting edge
    logic [3:0]  r_version;
    logic [3:0]  r_header_length;
    logic [7:0]  r_type_of_service;
    logic [15:0] r_total_length;
    logic [15:0] r_identification;
    logic [2:0]  r_flags;
    logic [12:0] r_fragment_offset;
    logic [7:0]  r_time_to_live;
    logic [7:0]  r_protocol;
    logic [31:0] r_src_ip_address;
    logic [31:0] r_dest_ip_address;

    logic [63:0] w_beat0;
    logic [63:0] w_beat1;
    logic [63:0] w_beat1_zero_cs;
    logic [63:0] w_beat2;
    logic [15:0] w_word;
    logic [16:0] w_sum17;
    logic [15:0] w_acc_next;
    logic        w_accept;

    assign w_accept = start && !busy;

    assign w_beat0 = {r_fragment_offset, r_flags, r_identification,
                      r_total_length, r_type_of_service,
                      r_header_length, r_version};

    // checksum_out already holds either the computed or the passed-through value
    assign w_beat1         = {r_src_ip_address, checksum_out, r_protocol, r_time_to_live};
    assign w_beat1_zero_cs = {r_src_ip_address, 16'h0000, r_protocol, r_time_to_live};
    assign w_beat2         = {32'h0000_0000, r_dest_ip_address};

    // Select the checksum word for the current CALC index (checksum field reads as zero)
    always_comb begin
        w_word = 16'h0000;
        case (r_idx)
            4'd0:    w_word = w_beat0[15:0];
            4'd1:    w_word = w_beat0[31:16];
            4'd2:    w_word = w_beat0[47:32];
            4'd3:    w_word = w_beat0[63:48];
            4'd4:    w_word = w_beat1_zero_cs[15:0];
            4'd5:    w_word = w_beat1_zero_cs[31:16];
            4'd6:    w_word = w_beat1_zero_cs[47:32];
            4'd7:    w_word = w_beat1_zero_cs[63:48];
            4'd8:    w_word = w_beat2[15:0];
            4'd9:    w_word = w_beat2[31:16];
            default: w_word = 16'h0000;
        endcase
    end

    // One's-complement add with end-around carry
    assign w_sum17    = {1'b0, r_acc} + {1'b0, w_word};
    assign w_acc_next = w_sum17[15:0] + {15'd0, w_sum17[16]};

    // Main control FSM; all outputs are registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_idx             <= 4'd0;
            r_acc             <= 16'h0000;
            busy              <= 1'b0;
            out_valid         <= 1'b0;
            out_last          <= 1'b0;
            out_data          <= 64'h0;
            out_beat          <= 2'd0;
            checksum_out      <= 16'h0000;
            r_version         <= 4'h0;
            r_header_length   <= 4'h0;
            r_type_of_service <= 8'h00;
            r_total_length    <= 16'h0000;
            r_identification  <= 16'h0000;
            r_flags           <= 3'h0;
            r_fragment_offset <= 13'h0000;
            r_time_to_live    <= 8'h00;
            r_protocol        <= 8'h00;
            r_src_ip_address  <= 32'h0;
            r_dest_ip_address <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_version         <= version;
                        r_header_length   <= header_length;
                        r_type_of_service <= type_of_service;
                        r_total_length    <= total_length;
                        r_identification  <= identification;
                        r_flags           <= flags;
                        r_fragment_offset <= fragment_offset;
                        r_time_to_live    <= time_to_live;
                        r_protocol        <= protocol;
                        r_src_ip_address  <= src_ip_address;
                        r_dest_ip_address <= dest_ip_address;
                        busy              <= 1'b1;
                        r_acc             <= 16'h0000;
                        r_idx             <= 4'd0;
                        if (COMPUTE_CHECKSUM) begin
                            r_state <= S_CALC;
                        end else begin
                            checksum_out <= checksum_in;
                            r_state      <= S_SEND0;
                        end
                    end
                end

                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + 4'd1;
                    if (r_idx == C_LAST_WORD) begin
                        checksum_out <= ~w_acc_next;
                        r_state      <= S_SEND0;
                    end
                end

                // First SEND0 cycle loads beat 0; afterwards wait for acceptance
                S_SEND0: begin
                    if (!out_valid) begin
                        out_data  <= w_beat0;
                        out_beat  <= 2'd0;
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_data <= w_beat1;
                        out_beat <= 2'd1;
                        r_state  <= S_SEND1;
                    end
                end

                S_SEND1: begin
                    if (out_ready) begin
                        out_data <= w_beat2;
                        out_beat <= 2'd2;
                        out_last <= 1'b1;
                        r_state  <= S_SEND2;
                    end
                end

                S_SEND2: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ip_header_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_header_encoder
// Purpose  : Directed self-checking bench for ip_header_encoder with the
//            checksum engine enabled (dut1) and in pass-through mode (dut0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ip_header_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0;
    logic        start0 = 1'b0;
    logic [3:0]  version = '0;
    logic [3:0]  header_length = '0;
    logic [7:0]  type_of_service = '0;
    logic [15:0] total_length = '0;
    logic [15:0] identification = '0;
    logic [2:0]  flags = '0;
    logic [12:0] fragment_offset = '0;
    logic [7:0]  time_to_live = '0;
    logic [7:0]  protocol = '0;
    logic [15:0] checksum_in = '0;
    logic [31:0] src_ip_address = '0;
    logic [31:0] dest_ip_address = '0;
    logic        out_ready = 1'b1;

    logic        busy1, valid1, last1;
    logic [63:0] data1;
    logic [1:0]  beat1;
    logic [15:0] cs1;
    logic        busy0, valid0, last0;
    logic [63:0] data0;
    logic [1:0]  beat0;
    logic [15:0] cs0;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] NOM_B0 = 64'h0002000000730054;
    localparam logic [63:0] NOM_B1 = 64'hC0A800016BDD1140;
    localparam logic [63:0] NOM_B2 = 64'h00000000C0A800C7;

    always #5 clk = ~clk;

    ip_header_encoder #(.COMPUTE_CHECKSUM(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .version(version), .header_length(header_length),
        .type_of_service(type_of_service), .total_length(total_length),
        .identification(identification), .flags(flags),
        .fragment_offset(fragment_offset), .time_to_live(time_to_live),
        .protocol(protocol), .checksum_in(checksum_in),
        .src_ip_address(src_ip_address), .dest_ip_address(dest_ip_address),
        .busy(busy1), .out_data(data1), .out_valid(valid1),
        .out_ready(out_ready), .out_last(last1), .out_beat(beat1),
        .checksum_out(cs1)
    );

    ip_header_encoder #(.COMPUTE_CHECKSUM(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .version(version), .header_length(header_length),
        .type_of_service(type_of_service), .total_length(total_length),
        .identification(identification), .flags(flags),
        .fragment_offset(fragment_offset), .time_to_live(time_to_live),
        .protocol(protocol), .checksum_in(checksum_in),
        .src_ip_address(src_ip_address), .dest_ip_address(dest_ip_address),
        .busy(busy0), .out_data(data0), .out_valid(valid0),
        .out_ready(out_ready), .out_last(last0), .out_beat(beat0),
        .checksum_out(cs0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [3:0] v, input logic [3:0] ihl, input logic [7:0] tos,
                              input logic [15:0] len, input logic [15:0] id, input logic [2:0] fl,
                              input logic [12:0] fo, input logic [7:0] ttl, input logic [7:0] pr,
                              input logic [15:0] csi, input logic [31:0] src, input logic [31:0] dst);
        version = v; header_length = ihl; type_of_service = tos; total_length = len;
        identification = id; flags = fl; fragment_offset = fo; time_to_live = ttl;
        protocol = pr; checksum_in = csi; src_ip_address = src; dest_ip_address = dst;
    endtask

    task automatic set_nominal(input logic [15:0] csi);
        set_fields(4'h4, 4'h5, 8'h00, 16'h0073, 16'h0000, 3'h2, 13'h0000,
                   8'h40, 8'h11, csi, 32'hC0A80001, 32'hC0A800C7);
    endtask

    // Counts cycles until dut1 raises out_valid, bounded
    task automatic wait_valid1(input string tag, input int exp_lat);
        int n = 0;
        while (!valid1 && n < 40) begin
            tick;
            n++;
        end
        chk(tag, 64'(n), 64'(exp_lat));
    endtask

    // Checks three back-to-back beats with out_ready high, then the idle return
    task automatic expect_beats(input string tag, input logic [63:0] e0,
                                input logic [63:0] e1, input logic [63:0] e2);
        chk({tag, "_b0"}, data1, e0);
        chk({tag, "_beat0"}, {62'd0, beat1}, 64'd0);
        chk({tag, "_last0"}, {63'd0, last1}, 64'd0);
        tick;
        start1 = 1'b0;
        chk({tag, "_b1"}, data1, e1);
        chk({tag, "_beat1"}, {62'd0, beat1}, 64'd1);
        chk({tag, "_last1"}, {63'd0, last1}, 64'd0);
        tick;
        chk({tag, "_b2"}, data1, e2);
        chk({tag, "_beat2"}, {62'd0, beat1}, 64'd2);
        chk({tag, "_last2"}, {63'd0, last1}, 64'd1);
        chk({tag, "_valid2"}, {63'd0, valid1}, 64'd1);
        tick;
        chk({tag, "_valid_end"}, {63'd0, valid1}, 64'd0);
        chk({tag, "_busy_end"}, {63'd0, busy1}, 64'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        chk("rst_busy", {63'd0, busy1}, 64'd0);
        chk("rst_valid", {63'd0, valid1}, 64'd0);
        chk("rst_data", data1, 64'd0);
        chk("rst_cs", {48'd0, cs1}, 64'd0);
        chk("rst_valid0", {63'd0, valid0}, 64'd0);

        // Nominal run
        set_nominal(16'h0000);
        out_ready = 1'b1;
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        chk("nom_busy", {63'd0, busy1}, 64'd1);
        chk("nom_valid_early", {63'd0, valid1}, 64'd0);
        wait_valid1("nom_latency", 11);
        chk("nom_cs", {48'd0, cs1}, 64'h6BDD);
        expect_beats("nom", NOM_B0, NOM_B1, NOM_B2);

        // Carry fold, started in the cycle right after final acceptance
        set_fields(4'hF, 4'hF, 8'hFF, 16'hFFFF, 16'hFFFF, 3'h7, 13'h1FFF,
                   8'hFF, 8'hFF, 16'h0000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        chk("fold_busy", {63'd0, busy1}, 64'd1);
        wait_valid1("fold_latency", 11);
        chk("fold_cs", {48'd0, cs1}, 64'h0000);
        expect_beats("fold", 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF0000FFFF, 64'h00000000FFFFFFFF);

        // Backpressure during SEND1
        set_nominal(16'h0000);
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        wait_valid1("bp_latency", 11);
        chk("bp_b0", data1, NOM_B0);
        tick;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_data", data1, NOM_B1);
            chk("bp_hold_beat", {62'd0, beat1}, 64'd1);
            tick;
        end
        chk("bp_hold_last", data1, NOM_B1);
        out_ready = 1'b1;
        tick;
        chk("bp_b2", data1, NOM_B2);
        chk("bp_last", {63'd0, last1}, 64'd1);
        tick;
        chk("bp_idle", {63'd0, valid1}, 64'd0);

        // Start pulses while busy are ignored
        set_nominal(16'h0000);
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        tick; tick; tick; tick;
        set_fields(4'h6, 4'h7, 8'hAA, 16'h1111, 16'h2222, 3'h1, 13'h0ABC,
                   8'h80, 8'h06, 16'h0000, 32'h0A000001, 32'h0A000002);
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        wait_valid1("ign_latency", 6);
        chk("ign_cs", {48'd0, cs1}, 64'h6BDD);
        start1 = 1'b1;
        expect_beats("ign", NOM_B0, NOM_B1, NOM_B2);

        // Reset in the middle of CALC
        set_nominal(16'h0000);
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mrst_busy", {63'd0, busy1}, 64'd0);
        chk("mrst_valid", {63'd0, valid1}, 64'd0);
        chk("mrst_cs", {48'd0, cs1}, 64'd0);
        tick;
        chk("mrst_stay_idle", {63'd0, valid1}, 64'd0);
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        wait_valid1("mrst_latency", 11);
        expect_beats("mrst", NOM_B0, NOM_B1, NOM_B2);

        // Pass-through checksum mode
        set_nominal(16'h1234);
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        chk("pt_busy", {63'd0, busy0}, 64'd1);
        chk("pt_valid_early", {63'd0, valid0}, 64'd0);
        tick;
        chk("pt_valid", {63'd0, valid0}, 64'd1);
        chk("pt_b0", data0, NOM_B0);
        chk("pt_cs", {48'd0, cs0}, 64'h1234);
        tick;
        chk("pt_b1", data0, 64'hC0A8000112341140);
        tick;
        chk("pt_b2", data0, NOM_B2);
        chk("pt_last", {63'd0, last0}, 64'd1);
        tick;
        chk("pt_end", {63'd0, busy0}, 64'd0);
        chk("pt_dut1_idle", {63'd0, busy1}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
